icache: RTL and testbench

//  Direct-mapped instruction cache; the responder end of the ifetch fetch handshake.

---
 rtl/icache_pkg.sv | 19 +
 rtl/icache_refill.sv | 32 +++
 rtl/icache.sv | 205 ++++++++++++++++++++
 tb/tb_icache.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared widths and FSM state encodings for the instruction cache.
package icache_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int INST_WIDTH = 32;

  typedef enum logic [1:0] {
    ICACHE_IDLE   = 2'd0,
    ICACHE_CMP    = 2'd1,
    ICACHE_REFILL = 2'd2,
    ICACHE_WAIT   = 2'd3
  } icache_state_e;

  // RISC-V: low two bits 2'b11 mark a 32-bit encoding, anything else is RVC.
  function automatic logic is_rvc(input logic [15:0] half);
    return half[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/icache_refill.sv
// Refill assembly: counts incoming bytes and gathers them into one line.
module icache_refill #(
  parameter int LINE_BYTES = 16
) (
  input  logic                    clk,
  input  logic                    rst_in,
  input  logic                    we_i,
  input  logic [7:0]              byte_i,
  output logic                    line_done_o,
  output logic [LINE_BYTES*8-1:0] line_data_o
);

  localparam int CNT_W = $clog2(LINE_BYTES);

  logic [CNT_W-1:0]        cnt_q;
  logic [LINE_BYTES*8-1:0] line_q;

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      cnt_q  <= '0;
      line_q <= '0;
    end else if (we_i) begin
      cnt_q                   <= cnt_q + 1'b1;
      line_q[{cnt_q, 3'b0}+:8] <= byte_i;
    end
  end

  assign line_done_o = we_i && (cnt_q == CNT_W'(LINE_BYTES - 1));
  // Last byte goes to the top of the line; forward it so the install sees a full line.
  assign line_data_o = {byte_i, line_q[LINE_BYTES*8-9:0]};

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache with RVC and line-straddling support.
// Optional build macro ICACHE_PERF_EN adds hit_cnt/miss_cnt outputs.
module icache
  import icache_pkg::*;
#(
  parameter int LINE_BYTES = 16,
  parameter int LINES      = 64
) (
  input  logic                  clk,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  fetch_en,
  input  logic [ADDR_WIDTH-1:0] fetch_pc,
  input  logic                  flush,
  output logic                  inst_rdy,
  output logic [INST_WIDTH-1:0] inst_out,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_vld,
  input  logic [7:0]            mem_byte
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]           hit_cnt,
  output logic [31:0]           miss_cnt
`endif
);

  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(LINES);
  localparam int TAG_W  = ADDR_WIDTH - OFF_W - IDX_W;
  localparam int LINE_W = LINE_BYTES * 8;

  icache_state_e         state_q, state_d;
  logic [ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
  logic                  drop_q, drop_d;
  logic                  inst_rdy_q, inst_rdy_d;
  logic [INST_WIDTH-1:0] inst_out_q, inst_out_d;
  logic                  mem_req_q, mem_req_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;

  logic [LINE_W-1:0] data_q [LINES];
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [LINES-1:0]  valid_q;

  logic              line_we;
  logic              line_done;
  logic [LINE_W-1:0] line_data;

  assign line_we = rdy_in && mem_vld && (state_q == ICACHE_REFILL);

  icache_refill #(.LINE_BYTES(LINE_BYTES)) u_refill (
    .clk        (clk),
    .rst_in     (rst_in),
    .we_i       (line_we),
    .byte_i     (mem_byte),
    .line_done_o(line_done),
    .line_data_o(line_data)
  );

  // Lookup on req_pc and on req_pc+2 (the second line of a straddling instruction).
  logic [ADDR_WIDTH-1:0] pc2;
  logic [IDX_W-1:0]      idx0, idx1, fill_idx;
  logic [TAG_W-1:0]      tag0, tag1, fill_tag;
  logic [OFF_W-1:0]      off;
  logic                  hit0, hit1, is32, straddle, all_hit;
  logic [LINE_W-1:0]     shifted, line1;
  logic [15:0]           half0;
  logic [INST_WIDTH-1:0] word;
  logic [ADDR_WIDTH-1:0] miss_addr;

  assign pc2      = req_pc_q + ADDR_WIDTH'(2);
  assign idx0     = req_pc_q[OFF_W+IDX_W-1:OFF_W];
  assign tag0     = req_pc_q[ADDR_WIDTH-1:OFF_W+IDX_W];
  assign idx1     = pc2[OFF_W+IDX_W-1:OFF_W];
  assign tag1     = pc2[ADDR_WIDTH-1:OFF_W+IDX_W];
  assign fill_idx = mem_addr_q[OFF_W+IDX_W-1:OFF_W];
  assign fill_tag = mem_addr_q[ADDR_WIDTH-1:OFF_W+IDX_W];
  assign off      = {req_pc_q[OFF_W-1:1], 1'b0};

  assign hit0     = valid_q[idx0] && (tag_q[idx0] == tag0);
  assign hit1     = valid_q[idx1] && (tag_q[idx1] == tag1);
  assign shifted  = data_q[idx0] >> {off, 3'b0};
  assign line1    = data_q[idx1];
  assign half0    = shifted[15:0];
  assign is32     = !is_rvc(half0);
  assign straddle = is32 && (off == OFF_W'(LINE_BYTES - 2));
  assign all_hit  = hit0 && (!straddle || hit1);

  always_comb begin
    word = {16'b0, half0};
    if (straddle)  word = {line1[15:0], half0};
    else if (is32) word = shifted[31:0];
  end

  assign miss_addr = hit0 ? {pc2[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}}
                          : {req_pc_q[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};

  logic unused_bits;
  assign unused_bits = ^{req_pc_q[0], pc2[OFF_W-1:0], mem_addr_q[OFF_W-1:0], shifted, line1};

  always_comb begin
    state_d    = state_q;
    req_pc_d   = req_pc_q;
    drop_d     = drop_q;
    inst_rdy_d = inst_rdy_q;
    inst_out_d = inst_out_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    case (state_q)
      ICACHE_IDLE: begin
        drop_d = 1'b0;
        if (fetch_en && !flush) begin
          req_pc_d = fetch_pc;
          state_d  = ICACHE_CMP;
        end
      end
      ICACHE_CMP: begin
        if (flush) begin
          state_d = ICACHE_IDLE;
        end else if (all_hit) begin
          inst_rdy_d = 1'b1;
          inst_out_d = word;
          state_d    = ICACHE_WAIT;
        end else begin
          mem_req_d  = 1'b1;
          mem_addr_d = miss_addr;
          state_d    = ICACHE_REFILL;
        end
      end
      ICACHE_WAIT: begin
        inst_rdy_d = 1'b0;
        state_d    = ICACHE_IDLE;
      end
      ICACHE_REFILL: begin
        // Memory cannot abort a burst, so a flush only marks the result as unwanted.
        if (flush) drop_d = 1'b1;
        if (line_done) begin
          mem_req_d = 1'b0;
          if (drop_q || flush) begin
            drop_d  = 1'b0;
            state_d = ICACHE_IDLE;
          end else begin
            state_d = ICACHE_CMP;
          end
        end
      end
      default: state_d = ICACHE_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= ICACHE_IDLE;
      req_pc_q   <= '0;
      drop_q     <= 1'b0;
      inst_rdy_q <= 1'b0;
      inst_out_q <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else if (rdy_in) begin
      state_q    <= state_d;
      req_pc_q   <= req_pc_d;
      drop_q     <= drop_d;
      inst_rdy_q <= inst_rdy_d;
      inst_out_q <= inst_out_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in)         valid_q           <= '0;
    else if (line_done) valid_q[fill_idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (line_done) begin
      data_q[fill_idx] <= line_data;
      tag_q[fill_idx]  <= fill_tag;
    end
  end

  assign inst_rdy = inst_rdy_q;
  assign inst_out = inst_out_q;
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_q, miss_q;

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (rdy_in && state_q == ICACHE_CMP) begin
      if (state_d == ICACHE_WAIT)   hit_q  <= hit_q + 32'd1;
      if (state_d == ICACHE_REFILL) miss_q <= miss_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_q;
  assign miss_cnt = miss_q;
`endif

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: stimulus queues expected instructions/refill addresses, monitors pop.
module tb_icache;
  import icache_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_in = 1'b1;
  logic                  rdy_in = 1'b1;
  logic                  fetch_en = 1'b0;
  logic [ADDR_WIDTH-1:0] fetch_pc = '0;
  logic                  flush = 1'b0;
  logic                  inst_rdy;
  logic [INST_WIDTH-1:0] inst_out;
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_vld = 1'b0;
  logic [7:0]            mem_byte = 8'h00;
`ifdef ICACHE_PERF_EN
  logic [31:0]           hit_cnt, miss_cnt;
`endif

  icache #(.LINE_BYTES(16), .LINES(64)) dut (
    .clk     (clk),
    .rst_in  (rst_in),
    .rdy_in  (rdy_in),
    .fetch_en(fetch_en),
    .fetch_pc(fetch_pc),
    .flush   (flush),
    .inst_rdy(inst_rdy),
    .inst_out(inst_out),
    .mem_req (mem_req),
    .mem_addr(mem_addr),
    .mem_vld (mem_vld),
    .mem_byte(mem_byte)
`ifdef ICACHE_PERF_EN
    ,
    .hit_cnt (hit_cnt),
    .miss_cnt(miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0]  mem [0:2047];
  logic [31:0] exp_inst_q [$];
  logic [31:0] exp_addr_q [$];
  int          bc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  // Byte-wide arbiter model: streams the requested line, one byte per cycle.
  always @(negedge clk) begin
    if (mem_req && rdy_in) begin
      mem_vld  = 1'b1;
      mem_byte = mem[(mem_addr + bc) % 2048];
      bc       = bc + 1;
    end else begin
      mem_vld = 1'b0;
      if (!mem_req) bc = 0;
    end
  end

  logic mon_req_pre;
  always @(posedge clk) begin
    mon_req_pre = mem_req;
    #1;
    if (!rst_in && mem_req && !mon_req_pre) begin
      if (exp_addr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_refill: got addr %h expected none", mem_addr);
      end else begin
        chk("refill_addr", mem_addr, exp_addr_q.pop_front());
      end
    end
  end

  // A frozen edge keeps the same pulse; an active edge with inst_rdy already high is a stretched pulse.
  logic mon_rdy_pre, mon_rdy_in;
  always @(posedge clk) begin
    mon_rdy_pre = inst_rdy;
    mon_rdy_in  = rdy_in;
    #1;
    if (!rst_in && inst_rdy) begin
      if (mon_rdy_pre && !mon_rdy_in) begin
      end else if (mon_rdy_pre) begin
        chk("inst_rdy_width", 32'd2, 32'd1);
      end else if (exp_inst_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_inst: got %h expected none", inst_out);
      end else begin
        chk("inst_out", inst_out, exp_inst_q.pop_front());
      end
    end
  end

  task automatic fetch(input logic [31:0] pc, input logic [31:0] exp, input int exp_lat,
                       input bit freeze);
    int lat;
    exp_inst_q.push_back(exp);
    @(negedge clk);
    fetch_en = 1'b1;
    fetch_pc = pc;
    @(negedge clk);
    fetch_en = 1'b0;
    lat = 0;
    while (!inst_rdy && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    if (!inst_rdy) begin
      fail_now("inst_timeout");
      return;
    end
    // A hit raises inst_rdy on the CMP edge right after the accept edge.
    if (exp_lat >= 0) chk("hit_latency", lat, exp_lat);
    if (freeze) begin
      rdy_in = 1'b0;
      repeat (3) begin
        @(negedge clk);
        chk("freeze_inst_rdy", {31'b0, inst_rdy}, 32'd1);
        chk("freeze_inst_out", inst_out, exp);
        chk("freeze_mem_req", {31'b0, mem_req}, 32'd0);
      end
      rdy_in = 1'b1;
    end
    @(negedge clk);
    chk("inst_rdy_drop", {31'b0, inst_rdy}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int t;
    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    {mem[3], mem[2], mem[1], mem[0]}             = 32'h00000513;
    {mem[7], mem[6], mem[5], mem[4]}             = 32'h00100593;
    {mem[9], mem[8]}                             = 16'h4501;
    {mem[15], mem[14]}                           = 16'h0513;
    {mem[35], mem[34], mem[33], mem[32]}         = 32'h00b505b3;
    {mem[1027], mem[1026], mem[1025], mem[1024]} = 32'h00000137;

    repeat (2) @(negedge clk);
    chk("rst_inst_rdy", {31'b0, inst_rdy}, 32'd0);
    chk("rst_inst_out", inst_out, 32'd0);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    rst_in = 1'b0;
    @(negedge clk);

    // Cold miss, then a hit in the freshly installed line.
    exp_addr_q.push_back(32'h0);
    fetch(32'h0, 32'h00000513, -1, 1'b0);
    fetch(32'h4, 32'h00100593, 1, 1'b0);
`ifdef ICACHE_PERF_EN
    chk("hit_cnt", hit_cnt, 32'd2);
    chk("miss_cnt", miss_cnt, 32'd1);
`endif

    fetch(32'h8, 32'h00004501, 1, 1'b0);

    // Straddle: low half in line 0x0, upper half needs line 0x10.
    exp_addr_q.push_back(32'h10);
    fetch(32'hE, 32'h00000513, -1, 1'b0);

    // Flush during refill: line still installs, no instruction returned.
    exp_addr_q.push_back(32'h20);
    @(negedge clk);
    fetch_en = 1'b1;
    fetch_pc = 32'h20;
    @(negedge clk);
    fetch_en = 1'b0;
    t = 0;
    while (bc < 5 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (bc < 5) fail_now("flush_refill_start");
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    t = 0;
    while (mem_req && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (mem_req) fail_now("flush_refill_end");
    repeat (5) @(negedge clk);
    chk("flush_no_req", {31'b0, mem_req}, 32'd0);
    chk("flush_no_inst", {31'b0, inst_rdy}, 32'd0);
    fetch(32'h20, 32'h00b505b3, 1, 1'b0);

    // flush wins over fetch_en in IDLE.
    @(negedge clk);
    fetch_en = 1'b1;
    flush    = 1'b1;
    fetch_pc = 32'h30;
    @(negedge clk);
    fetch_en = 1'b0;
    flush    = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_flush_no_req", {31'b0, mem_req}, 32'd0);

    // Conflict: 0x400 evicts line 0, so 0x0 misses again.
    exp_addr_q.push_back(32'h400);
    fetch(32'h400, 32'h00000137, -1, 1'b0);
    exp_addr_q.push_back(32'h0);
    fetch(32'h0, 32'h00000513, -1, 1'b0);

    // Freeze for three cycles while inst_rdy is high.
    fetch(32'h4, 32'h00100593, 1, 1'b1);

    repeat (3) @(negedge clk);
    chk("pending_inst", exp_inst_q.size(), 32'd0);
    chk("pending_refill", exp_addr_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
